// File: rtl/arm_mem_pkg.sv
// Shared types and lane helpers for the ARM core memory bridge.
// Lane functions work one byte lane at a time so they hold for any DATA_W.
package arm_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Byte enable for one lane: every lane for word ops, only the addressed lane for byte ops.
  function automatic logic lane_enable(input logic byte_op, input int sel, input int lane);
    return !byte_op || (sel == lane);
  endfunction

  // Write byte for one lane: byte ops replicate the low byte across all lanes.
  function automatic logic [7:0] lane_byte(input logic byte_op, input logic [7:0] low,
                                           input logic [7:0] own);
    return byte_op ? low : own;
  endfunction

endpackage

// File: rtl/arm_lane_steer.sv
// Combinational byte-lane steering: write enables/data toward memory and
// zero-extended byte extraction on the read path.
module arm_lane_steer
  import arm_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BE_W   = DATA_W / 8,
  parameter int LANE_W = $clog2(BE_W)
) (
  input  logic              byte_op,
  input  logic [LANE_W-1:0] lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] steered_wdata,
  output logic [DATA_W-1:0] extracted_rdata
);

  logic [7:0] rbyte;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign be[gi]                  = lane_enable(byte_op, int'(lane), gi);
    assign steered_wdata[8*gi +: 8] = lane_byte(byte_op, wdata[7:0], wdata[8*gi +: 8]);
  end

  assign rbyte           = rdata[{lane, 3'b000} +: 8];
  assign extracted_rdata = byte_op ? {{(DATA_W-8){1'b0}}, rbyte} : rdata;

endmodule

// File: rtl/arm_mem_bridge.sv
// Bridge from the multicycle core's memory port to a req/ack memory, with
// core stall, byte-lane handling and a bus timeout that sets a sticky error.
module arm_mem_bridge
  import arm_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              MemWrite,
  input  logic              ByteOp,
  input  logic [ADDR_W-1:0] Adr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              BusErr,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LANE_W = $clog2(BE_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [LANE_W-1:0] lane_reg;
  logic              byte_reg;

  logic              sel_byte;
  logic [LANE_W-1:0] sel_lane;
  logic [BE_W-1:0]   steer_be;
  logic [DATA_W-1:0] steer_wdata;
  logic [DATA_W-1:0] steer_rdata;

  // The write side is only used while capturing in IDLE (live core inputs),
  // the read side only in REQ (latched access), so one steering block serves both.
  assign sel_byte = (state_reg == IDLE) ? ByteOp : byte_reg;
  assign sel_lane = (state_reg == IDLE) ? Adr[LANE_W-1:0] : lane_reg;

  arm_lane_steer #(
    .DATA_W (DATA_W),
    .BE_W   (BE_W),
    .LANE_W (LANE_W)
  ) u_steer (
    .byte_op         (sel_byte),
    .lane            (sel_lane),
    .wdata           (WriteData),
    .rdata           (mem_rdata),
    .be              (steer_be),
    .steered_wdata   (steer_wdata),
    .extracted_rdata (steer_rdata)
  );

  always_comb begin
    Stall = 1'b0;
    case (state_reg)
      IDLE:    Stall = core_req;
      REQ:     Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      lane_reg  <= '0;
      byte_reg  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      ReadData  <= '0;
      BusErr    <= 1'b0;
    end else begin
      // A timeout in the same cycle overrides this clear below.
      if (err_clr) BusErr <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (core_req) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_adr   <= {Adr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
            mem_be    <= steer_be;
            mem_wdata <= steer_wdata;
            lane_reg  <= Adr[LANE_W-1:0];
            byte_reg  <= ByteOp;
            cnt_reg   <= '0;
            state_reg <= REQ;
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mem_ack) begin
            ReadData  <= steer_rdata;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            BusErr    <= 1'b1;
            ReadData  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_mem_bridge.sv
// Self-checking bench for arm_mem_bridge: directed cases followed by random
// accesses, checked against a behavioural model of the bridge's rules.
module tb_arm_mem_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req;
  logic        MemWrite;
  logic        ByteOp;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        BusErr;
  logic        err_clr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_buserr;
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  arm_mem_bridge #(
    .DATA_W  (32),
    .ADDR_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core_req  (core_req),
    .MemWrite  (MemWrite),
    .ByteOp    (ByteOp),
    .Adr       (Adr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .BusErr    (BusErr),
    .err_clr   (err_clr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference rules, little-endian lanes: lane = address mod 4.
  function automatic logic [31:0] ref_read(input logic bop, input logic [31:0] adr,
                                           input logic [31:0] rd);
    if (bop) return (rd >> (8 * (adr % 4))) & 32'hFF;
    return rd;
  endfunction

  function automatic logic [3:0] ref_be(input logic bop, input logic [31:0] adr);
    if (bop) return 4'(1 << (adr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic bop, input logic [31:0] wd);
    if (bop) return (wd % 256) * 32'h01010101;
    return wd;
  endfunction

  // One complete core access; entered and left 1 ns after a rising edge in IDLE.
  // ack_at = index of the mem_req cycle carrying mem_ack (>= TO means no ack).
  task automatic access(input logic we, input logic bop, input logic [31:0] adr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_at, input logic hold_clr);
    bit done = 0;
    bit tmo;
    core_req  = 1'b1;
    MemWrite  = we;
    ByteOp    = bop;
    Adr       = adr;
    WriteData = wd;
    #1 check("stall_on_request", Stall, 1);
    @(posedge clk); #1;
    check("mem_adr", mem_adr, adr & ~32'h3);
    check("mem_be", mem_be, ref_be(bop, adr));
    check("mem_wdata", mem_wdata, ref_wdata(bop, wd));
    check("mem_we", mem_we, we);
    for (int k = 0; k < TO && !done; k++) begin
      check("mem_req_high", mem_req, 1);
      check("stall_in_req", Stall, 1);
      err_clr   = hold_clr;
      mem_ack   = (k == ack_at);
      mem_rdata = (k == ack_at) ? rd : $urandom;
      @(posedge clk); #1;
      tmo = (k != ack_at) && (k == TO - 1);
      if (k == ack_at) begin
        exp_rd = ref_read(bop, adr, rd);
        done   = 1;
      end else if (tmo) begin
        exp_rd = '0;
        done   = 1;
      end
      if (tmo) exp_buserr = 1'b1;
      else if (hold_clr) exp_buserr = 1'b0;
    end
    mem_ack = 1'b0;
    err_clr = 1'b0;
    check("done_mem_req_low", mem_req, 0);
    check("done_stall_low", Stall, 0);
    check("done_readdata", ReadData, exp_rd);
    check("done_buserr", BusErr, exp_buserr);
    core_req = 1'b0;
    @(posedge clk); #1;
    check("idle_stall", Stall, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_readdata_held", ReadData, exp_rd);
    $display("access we=%0d byte=%0d adr=0x%08h ack_at=%0d -> ReadData=0x%08h BusErr=%0d",
             we, bop, adr, ack_at, ReadData, BusErr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; core_req = 1'b0; MemWrite = 1'b0; ByteOp = 1'b0;
    Adr = '0; WriteData = '0; err_clr = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    exp_buserr = 1'b0;
    exp_rd     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_adr", mem_adr, 0);
    check("reset_mem_wdata", mem_wdata, 0);
    check("reset_mem_be", mem_be, 0);
    check("reset_readdata", ReadData, 0);
    check("reset_buserr", BusErr, 0);
    check("reset_stall", Stall, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Word load, ack on the last allowed cycle (TIMEOUT-1): ack must win.
    access(1'b0, 1'b0, 32'h104, 32'h0, 32'hDEADBEEF, 3, 1'b0);
    // Byte store to the top lane.
    access(1'b1, 1'b1, 32'h203, 32'h000000A5, 32'h12345678, 1, 1'b0);
    // Byte loads from two lanes, including the fastest possible ack.
    access(1'b0, 1'b1, 32'h11, 32'h0, 32'h44332211, 0, 1'b0);
    access(1'b0, 1'b1, 32'h12, 32'h0, 32'h44332211, 2, 1'b0);

    // Timeout, then an err_clr pulse.
    access(1'b0, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, TO, 1'b0);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr    = 1'b0;
    exp_buserr = 1'b0;
    check("err_clr_clears", BusErr, exp_buserr);

    // Timeout while err_clr is held: set wins.
    access(1'b1, 1'b0, 32'h404, 32'h11223344, 32'h0, TO, 1'b1);

    // Spurious ack while idle.
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAADF00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("spurious_mem_req", mem_req, 0);
    check("spurious_stall", Stall, 0);
    check("spurious_readdata", ReadData, exp_rd);
    check("spurious_buserr", BusErr, exp_buserr);
    @(posedge clk); #1;
    check("spurious_mem_req_later", mem_req, 0);
    check("spurious_readdata_later", ReadData, exp_rd);

    // Reset in the middle of an access.
    core_req = 1'b1; MemWrite = 1'b0; ByteOp = 1'b0; Adr = 32'h500;
    @(posedge clk); #1;
    check("pre_reset_mem_req", mem_req, 1);
    @(posedge clk); #1;
    reset    = 1'b1;
    core_req = 1'b0;
    @(posedge clk); #1;
    reset      = 1'b0;
    exp_buserr = 1'b0;
    exp_rd     = '0;
    check("midreset_mem_req", mem_req, 0);
    check("midreset_stall", Stall, 0);
    check("midreset_buserr", BusErr, 0);
    check("midreset_readdata", ReadData, 0);
    @(posedge clk); #1;
    check("midreset_stays_idle", mem_req, 0);
    access(1'b0, 1'b0, 32'h600, 32'h0, 32'h0BADCAFE, 1, 1'b0);

    // Random accesses.
    for (int i = 0; i < 40; i++) begin
      logic        we, bop, hc;
      logic [31:0] adr, wd, rd;
      int          ack_at;
      we     = 1'($urandom_range(0, 1));
      bop    = 1'($urandom_range(0, 1));
      adr    = $urandom;
      wd     = $urandom;
      rd     = $urandom;
      ack_at = $urandom_range(0, TO + 1);
      hc     = ($urandom_range(0, 7) == 0);
      access(we, bop, adr, wd, rd, ack_at, hc);
      if ($urandom_range(0, 3) == 0) begin
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr    = 1'b0;
        exp_buserr = 1'b0;
        check("rand_err_clr", BusErr, exp_buserr);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
